lsu_retire_ctrl: RTL

Sequences retirement of memory ops between the ROB, load queue (LQ), store queue (SQ) and data-cache write port.
- Loads: issues the LQ retire and returns the LQ mis-speculation flag to the ROB.
- Stores: triggers the SQ retire, waits for the D$ write to complete, then fires the store-retire probe into the LQ.
- Handles one retiring op at a time, sitting between the ROB retire port and the LSU queues.

---
 rtl/lsu_retire_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/lsu_retire_ctrl.sv
// lsu_retire_ctrl
// Retires one memory op at a time between the ROB retire port and the LSU.
// A load frees its LQ entry and hands the LQ mis-speculation flag back to the
// ROB. A store is sent to the SQ for its D$ write. Once that write completes,
// the store-retire probe fires into the LQ and the ROB receives its ack.

module lsu_retire_ctrl #(
   parameter int TAG_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 i_flush,
   input  logic                 i_rob_retire_en,
   input  logic [TAG_WIDTH-1:0] i_rob_retire_tag,
   input  logic                 i_rob_retire_is_store,
   output logic                 o_rob_retire_ack,
   output logic                 o_rob_retire_mis_speculated,
   output logic                 o_lq_retire_en,
   output logic [TAG_WIDTH-1:0] o_lq_retire_tag,
   input  logic                 i_lq_retire_mis_speculated,
   output logic                 o_sq_retire_en,
   output logic [TAG_WIDTH-1:0] o_sq_retire_tag,
   input  logic                 i_dc_wr_done,
   output logic                 o_lq_sq_retire_en,
   output logic                 o_busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LD_RETIRE = 3'd1,
      ST_REQ    = 3'd2,
      ST_WAIT   = 3'd3,
      ACK       = 3'd4
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [TAG_WIDTH-1:0] tag_r;
   logic                 is_store_r;
   logic                 misspec_r;

   // State register; reset abandons any op in flight without acking it
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the accepted request, then record the LQ flag (loads) or clear it (stores)
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tag_r      <= '0;
         is_store_r <= 1'b0;
         misspec_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_rob_retire_en && !i_flush) begin
                  tag_r      <= i_rob_retire_tag;
                  is_store_r <= i_rob_retire_is_store;
               end
            end
            LD_RETIRE: misspec_r <= i_lq_retire_mis_speculated;
            ST_REQ:    misspec_r <= 1'b0;
            default:   ;
         endcase
      end
   end

   // Next-state and output decode. A flush is ignored in ST_WAIT because the
   // store is already committed, except on the done cycle where it suppresses the ack
   always_comb begin
      state_nxt                   = state;
      o_rob_retire_ack            = 1'b0;
      o_rob_retire_mis_speculated = 1'b0;
      o_lq_retire_en              = 1'b0;
      o_lq_retire_tag             = '0;
      o_sq_retire_en              = 1'b0;
      o_sq_retire_tag             = '0;
      o_lq_sq_retire_en           = 1'b0;
      o_busy                      = (state != IDLE);

      case (state)
         IDLE: begin
            if (i_rob_retire_en && !i_flush) begin
               state_nxt = i_rob_retire_is_store ? ST_REQ : LD_RETIRE;
            end
         end
         LD_RETIRE: begin
            o_lq_retire_en  = 1'b1;
            o_lq_retire_tag = tag_r;
            state_nxt       = i_flush ? IDLE : ACK;
         end
         ST_REQ: begin
            o_sq_retire_en  = 1'b1;
            o_sq_retire_tag = tag_r;
            state_nxt       = i_flush ? IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (i_dc_wr_done) begin
               o_lq_sq_retire_en = 1'b1;
               state_nxt         = i_flush ? IDLE : ACK;
            end
         end
         ACK: begin
            o_rob_retire_ack            = 1'b1;
            o_rob_retire_mis_speculated = misspec_r && !is_store_r;
            state_nxt                   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
